// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Desc    : 1280x800@60 raster timing constants and shared video types
// Rev     : 1.0  initial release
// ============================================================================
package vga_pkg;

    localparam int c_h_active = 1280;
    localparam int c_h_fp     = 72;
    localparam int c_h_sync   = 128;
    localparam int c_h_bp     = 200;
    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

    localparam int c_v_active = 800;
    localparam int c_v_fp     = 3;
    localparam int c_v_sync   = 6;
    localparam int c_v_bp     = 22;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    // Coordinate widths agreed with the background renderer
    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/sync_delay.sv
`default_nettype none
// ============================================================================
// Module  : sync_delay
// Desc    : DEPTH-stage shift register, reset to RESET_VAL; wire when DEPTH=0
// Rev     : 1.0  initial release
// ============================================================================
module sync_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = ^{clk, rst};
            assign dout     = din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
                end else begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule : sync_delay
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Desc    : raster counters, renderer coordinates, latency-matched VGA pins
// Rev     : 1.0  initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = c_h_active,
    parameter int   H_FP     = c_h_fp,
    parameter int   H_SYNC   = c_h_sync,
    parameter int   H_BP     = c_h_bp,
    parameter int   V_ACTIVE = c_v_active,
    parameter int   V_FP     = c_v_fp,
    parameter int   V_SYNC   = c_v_sync,
    parameter int   V_BP     = c_v_bp,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b1,
    parameter int   PIPE_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    output logic [X_W-1:0] curr_x,
    output logic [Y_W-1:0] curr_y,
    input  logic [3:0]     pix_r,
    input  logic [3:0]     pix_g,
    input  logic [3:0]     pix_b,
    output logic           vga_hs,
    output logic           vga_vs,
    output logic           vga_de,
    output logic [3:0]     vga_r,
    output logic [3:0]     vga_g,
    output logic [3:0]     vga_b,
    output logic           frame_start,
    output logic           line_start
);

    localparam logic [X_W-1:0] c_h_act_end  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] c_h_sync_beg = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] c_h_sync_end = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [X_W-1:0] c_h_last     = X_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    localparam logic [Y_W-1:0] c_v_act_end  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] c_v_sync_beg = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] c_v_sync_end = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [Y_W-1:0] c_v_last     = Y_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // {hs, vs, de} with every signal deasserted
    localparam logic [2:0] c_sync_idle = {~HS_POL, ~VS_POL, 1'b0};

    logic [X_W-1:0] r_h_cnt;
    logic [Y_W-1:0] r_v_cnt;
    logic           w_h_act;
    logic           w_v_act;
    logic           w_h_sync;
    logic           w_v_sync;
    logic           r_hs;
    logic           r_vs;
    logic           r_de;
    logic [2:0]     w_sync_dly;
    rgb12_t         w_pix;
    rgb12_t         r_rgb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_h_act  = (r_h_cnt < c_h_act_end);
    assign w_v_act  = (r_v_cnt < c_v_act_end);
    assign w_h_sync = (r_h_cnt >= c_h_sync_beg) && (r_h_cnt < c_h_sync_end);
    assign w_v_sync = (r_v_cnt >= c_v_sync_beg) && (r_v_cnt < c_v_sync_end);

    // Coordinates are clamped to 0 in blanking so the renderer never indexes past the map
    always_ff @(posedge clk) begin
        if (!rst) begin
            curr_x      <= '0;
            curr_y      <= '0;
            r_hs        <= ~HS_POL;
            r_vs        <= ~VS_POL;
            r_de        <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            curr_x      <= w_h_act ? r_h_cnt : '0;
            curr_y      <= w_v_act ? r_v_cnt : '0;
            r_hs        <= w_h_sync ? HS_POL : ~HS_POL;
            r_vs        <= w_v_sync ? VS_POL : ~VS_POL;
            r_de        <= w_h_act && w_v_act;
            frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            line_start  <= (r_h_cnt == '0) && w_v_act;
        end
    end

    sync_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL (c_sync_idle)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({r_hs, r_vs, r_de}),
        .dout (w_sync_dly)
    );

    assign w_pix = '{r: pix_r, g: pix_g, b: pix_b};

    always_ff @(posedge clk) begin
        if (!rst) begin
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
            vga_de <= 1'b0;
            r_rgb  <= '0;
        end else begin
            vga_hs <= w_sync_dly[2];
            vga_vs <= w_sync_dly[1];
            vga_de <= w_sync_dly[0];
            r_rgb  <= w_sync_dly[0] ? w_pix : '0;
        end
    end

    assign vga_r = r_rgb.r;
    assign vga_g = r_rgb.g;
    assign vga_b = r_rgb.b;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_gen
// Desc    : self-checking bench, reduced raster, PIPE_LAT=2 and PIPE_LAT=0 builds
// Rev     : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int TH_ACT  = 16;
    localparam int TH_FP   = 3;
    localparam int TH_SYNC = 4;
    localparam int TH_BP   = 5;
    localparam int TV_ACT  = 10;
    localparam int TV_FP   = 2;
    localparam int TV_SYNC = 3;
    localparam int TV_BP   = 2;
    localparam int HT      = TH_ACT + TH_FP + TH_SYNC + TH_BP;
    localparam int VT      = TV_ACT + TV_FP + TV_SYNC + TV_BP;
    localparam int FRAME   = HT * VT;
    localparam logic [14:0] PIN_IDLE = 15'h4000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic [10:0] curr_x, curr_x_0;
    logic [9:0]  curr_y, curr_y_0;
    logic [11:0] p1, p2, pix0;
    logic        vga_hs, vga_vs, vga_de, frame_start, line_start;
    logic        vga_hs_0, vga_vs_0, vga_de_0, frame_start_0, line_start_0;
    logic [3:0]  vga_r, vga_g, vga_b, vga_r_0, vga_g_0, vga_b_0;

    always #5 clk = ~clk;

    function automatic logic [11:0] rend(logic [10:0] x, logic [9:0] y);
        return {x[3:0], y[3:0], 4'hA};
    endfunction

    // Renderer models: two-clock pipeline for dut, combinational for dut_0
    always @(posedge clk) begin
        p1 <= rend(curr_x, curr_y);
        p2 <= p1;
    end
    assign pix0 = rend(curr_x_0, curr_y_0);

    vga_timing_gen #(
        .H_ACTIVE(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
        .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
        .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .curr_x(curr_x), .curr_y(curr_y),
        .pix_r(p2[11:8]), .pix_g(p2[7:4]), .pix_b(p2[3:0]),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .line_start(line_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
        .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
        .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_LAT(0)
    ) dut_0 (
        .clk(clk), .rst(rst), .curr_x(curr_x_0), .curr_y(curr_y_0),
        .pix_r(pix0[11:8]), .pix_g(pix0[7:4]), .pix_b(pix0[3:0]),
        .vga_hs(vga_hs_0), .vga_vs(vga_vs_0), .vga_de(vga_de_0),
        .vga_r(vga_r_0), .vga_g(vga_g_0), .vga_b(vga_b_0),
        .frame_start(frame_start_0), .line_start(line_start_0)
    );

    wire [14:0] pins   = {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b};
    wire [14:0] pins_0 = {vga_hs_0, vga_vs_0, vga_de_0, vga_r_0, vga_g_0, vga_b_0};
    wire [22:0] coord  = {curr_x, curr_y, frame_start, line_start};
    wire [22:0] coord_0 = {curr_x_0, curr_y_0, frame_start_0, line_start_0};

    // Expected pin word {hs, vs, de, rgb} for raster position (h, v)
    function automatic logic [14:0] pin_of(int h, int v);
        logic        de, hs, vs;
        logic [10:0] x;
        logic [9:0]  y;
        de = (h < TH_ACT) && (v < TV_ACT);
        hs = (h >= TH_ACT + TH_FP && h < TH_ACT + TH_FP + TH_SYNC) ? 1'b0 : 1'b1;
        vs = (v >= TV_ACT + TV_FP && v < TV_ACT + TV_FP + TV_SYNC) ? 1'b1 : 1'b0;
        x  = 11'(h);
        y  = 10'(v);
        return {hs, vs, de, (de ? rend(x, y) : 12'h000)};
    endfunction

    function automatic logic [22:0] coord_of(int h, int v);
        logic [10:0] x;
        logic [9:0]  y;
        x = (h < TH_ACT) ? 11'(h) : 11'd0;
        y = (v < TV_ACT) ? 10'(v) : 10'd0;
        return {x, y, (h == 0 && v == 0), (h == 0 && v < TV_ACT)};
    endfunction

    // Holds reset for n clocks and returns just before the releasing edge
    task automatic apply_reset(int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (pins !== PIN_IDLE) begin
                bad++;
                $display("FAIL reset_pins cyc%0d: got %h want %h", k, pins, PIN_IDLE);
            end
            total++;
            if (coord !== 23'd0 || pins_0 !== PIN_IDLE) begin
                bad++;
                $display("FAIL reset_coord cyc%0d: got %h/%h want 0/%h", k, coord, pins_0, PIN_IDLE);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (coord !== coord_of(0, 0) || coord_0 !== coord_of(0, 0)) begin
            bad++;
            $display("FAIL release_first: got %h/%h want %h", coord, coord_0, coord_of(0, 0));
        end
    endtask

    task automatic test_line();
        int de_hi = 0, hs_lo = 0, first_hs = -1;
        apply_reset(2);
        for (int k = 1; k <= HT + 3; k++) begin
            @(negedge clk);
            if (k == 3 || k == 4) begin
                total++;
                if (vga_de !== (k == 4)) begin
                    bad++;
                    $display("FAIL de_latency k%0d: got %b want %b", k, vga_de, (k == 4));
                end
            end
            if (k == 1 || k == 2) begin
                total++;
                if (vga_de_0 !== (k == 2)) begin
                    bad++;
                    $display("FAIL de_latency_lat0 k%0d: got %b want %b", k, vga_de_0, (k == 2));
                end
            end
            if (k >= 4) begin
                if (vga_de) de_hi++;
                if (!vga_hs) begin
                    hs_lo++;
                    if (first_hs < 0) first_hs = k;
                end
            end
        end
        total++;
        if (de_hi !== TH_ACT) begin
            bad++;
            $display("FAIL line_de_high: got %0d want %0d", de_hi, TH_ACT);
        end
        total++;
        if (hs_lo !== TH_SYNC) begin
            bad++;
            $display("FAIL line_hs_low: got %0d want %0d", hs_lo, TH_SYNC);
        end
        total++;
        if (first_hs !== 4 + TH_ACT + TH_FP) begin
            bad++;
            $display("FAIL line_hs_start: got %0d want %0d", first_hs, 4 + TH_ACT + TH_FP);
        end
    endtask

    task automatic test_frame();
        int next_fs = -1, ls_cnt = 0, vs_cnt = 0, first_vs = -1, y_bad = 0;
        apply_reset(2);
        for (int k = 1; k <= 2 * FRAME + 8 && next_fs < 0; k++) begin
            @(negedge clk);
            if (k > 1 && frame_start) next_fs = k;
            if (k <= FRAME && line_start) ls_cnt++;
            if (k >= 4 && k <= FRAME + 3 && vga_vs) begin
                vs_cnt++;
                if (first_vs < 0) first_vs = k;
            end
            if (k <= FRAME && ((k - 1) / HT) >= TV_ACT && curr_y !== 10'd0) y_bad++;
        end
        total++;
        if (next_fs !== FRAME + 1) begin
            bad++;
            $display("FAIL frame_period: got %0d want %0d", next_fs, FRAME + 1);
        end
        total++;
        if (ls_cnt !== TV_ACT) begin
            bad++;
            $display("FAIL line_start_count: got %0d want %0d", ls_cnt, TV_ACT);
        end
        total++;
        if (vs_cnt !== TV_SYNC * HT || first_vs !== 4 + (TV_ACT + TV_FP) * HT) begin
            bad++;
            $display("FAIL frame_vs: got len %0d start %0d want len %0d start %0d",
                     vs_cnt, first_vs, TV_SYNC * HT, 4 + (TV_ACT + TV_FP) * HT);
        end
        total++;
        if (y_bad !== 0) begin
            bad++;
            $display("FAIL curr_y_blank: got %0d nonzero cycles want 0", y_bad);
        end
    endtask

    task automatic test_pixels();
        logic [14:0] q[$];
        logic [14:0] q0[$];
        logic [14:0] exp_pin;
        int h, v;
        apply_reset(2);
        repeat (3) q.push_back(PIN_IDLE);
        q0.push_back(PIN_IDLE);
        for (int k = 1; k <= FRAME + 40; k++) begin
            @(negedge clk);
            h = (k - 1) % HT;
            v = ((k - 1) / HT) % VT;
            total++;
            if (coord !== coord_of(h, v) || coord_0 !== coord_of(h, v)) begin
                bad++;
                $display("FAIL coord h%0d v%0d: got %h/%h want %h", h, v, coord, coord_0, coord_of(h, v));
            end
            q.push_back(pin_of(h, v));
            q0.push_back(pin_of(h, v));
            exp_pin = q.pop_front();
            total++;
            if (pins !== exp_pin) begin
                bad++;
                $display("FAIL pins k%0d: got %h want %h", k, pins, exp_pin);
            end
            exp_pin = q0.pop_front();
            total++;
            if (pins_0 !== exp_pin) begin
                bad++;
                $display("FAIL pins_lat0 k%0d: got %h want %h", k, pins_0, exp_pin);
            end
        end
    endtask

    task automatic test_midreset();
        int next_fs = -1;
        apply_reset(2);
        repeat (4 * HT + 8) @(negedge clk);
        total++;
        if (coord !== coord_of(7, 4)) begin
            bad++;
            $display("FAIL mid_position: got %h want %h", coord, coord_of(7, 4));
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (coord !== 23'd0 || coord_0 !== 23'd0) begin
            bad++;
            $display("FAIL mid_reset_coord: got %h/%h want 0", coord, coord_0);
        end
        total++;
        if (pins !== PIN_IDLE || pins_0 !== PIN_IDLE) begin
            bad++;
            $display("FAIL mid_reset_pins: got %h/%h want %h", pins, pins_0, PIN_IDLE);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (coord !== coord_of(0, 0)) begin
            bad++;
            $display("FAIL mid_restart: got %h want %h", coord, coord_of(0, 0));
        end
        for (int k = 2; k <= 2 * FRAME + 8 && next_fs < 0; k++) begin
            @(negedge clk);
            if (frame_start) next_fs = k;
        end
        total++;
        if (next_fs !== FRAME + 1) begin
            bad++;
            $display("FAIL mid_frame_period: got %0d want %0d", next_fs, FRAME + 1);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_pixels();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
